// File: rtl/de_ex_pipeline_register.sv
// -----------------------------------------------------------------------------
// de_ex_pipeline_register
//
// Purpose:
//   DE/EX pipeline register for a 5-stage RISC-V style core. It captures every
//   decode-stage field into the EX stage on each rising clock edge. A load-use
//   stall (HDUStall) or a taken branch/jump resolved in EX (NextPCSrc) turns the
//   EX slot into an all-zero bubble. The stage never holds; the upstream IF/DE
//   register and PC hold the stalled instruction. Two saturating 16-bit
//   counters report how many stall bubbles and flush bubbles were inserted.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   HDUStall                  load-use stall request (bubble, counted as stall)
//   NextPCSrc                 branch/jump flush request (bubble, counted as flush)
//   pc_de, ru_rs1_de,
//   ru_rs2_de, imm_de   [31:0] DE-stage PC, register-file data, immediate
//   rs1_de, rs2_de, rd_de [4:0] DE-stage register indices
//   RUWr_de, DMWr_de, DMRd_de,
//   ALUASrc_de, ALUBSrc_de     DE-stage single-bit controls
//   ALUOp_de [3:0], BrOp_de [4:0],
//   DMCtrl_de [2:0], RUDataWrSrc_de [1:0]  DE-stage control fields
//   *_ex                      registered copies of every DE field
//   valid_ex                  1 = EX holds a real instruction, 0 = bubble
//   stall_cnt, flush_cnt [15:0] saturating bubble counters
// -----------------------------------------------------------------------------
module de_ex_pipeline_register (
    input  logic        clk,
    input  logic        rst,
    input  logic        HDUStall,
    input  logic        NextPCSrc,
    input  logic [31:0] pc_de,
    input  logic [31:0] ru_rs1_de,
    input  logic [31:0] ru_rs2_de,
    input  logic [31:0] imm_de,
    input  logic [4:0]  rs1_de,
    input  logic [4:0]  rs2_de,
    input  logic [4:0]  rd_de,
    input  logic        RUWr_de,
    input  logic        DMWr_de,
    input  logic        DMRd_de,
    input  logic        ALUASrc_de,
    input  logic        ALUBSrc_de,
    input  logic [3:0]  ALUOp_de,
    input  logic [4:0]  BrOp_de,
    input  logic [2:0]  DMCtrl_de,
    input  logic [1:0]  RUDataWrSrc_de,
    output logic [31:0] pc_ex,
    output logic [31:0] ru_rs1_ex,
    output logic [31:0] ru_rs2_ex,
    output logic [31:0] imm_ex,
    output logic [4:0]  rs1_ex,
    output logic [4:0]  rs2_ex,
    output logic [4:0]  rd_ex,
    output logic        RUWr_ex,
    output logic        DMWr_ex,
    output logic        DMRd_ex,
    output logic        ALUASrc_ex,
    output logic        ALUBSrc_ex,
    output logic [3:0]  ALUOp_ex,
    output logic [4:0]  BrOp_ex,
    output logic [2:0]  DMCtrl_ex,
    output logic [1:0]  RUDataWrSrc_ex,
    output logic        valid_ex,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    logic        bubble_s;
    logic        stall_evt_s;
    logic        flush_evt_s;

    logic [31:0] pc_d,          pc_q;
    logic [31:0] ru_rs1_d,      ru_rs1_q;
    logic [31:0] ru_rs2_d,      ru_rs2_q;
    logic [31:0] imm_d,         imm_q;
    logic [4:0]  rs1_d,         rs1_q;
    logic [4:0]  rs2_d,         rs2_q;
    logic [4:0]  rd_d,          rd_q;
    logic        ruwr_d,        ruwr_q;
    logic        dmwr_d,        dmwr_q;
    logic        dmrd_d,        dmrd_q;
    logic        alu_a_src_d,   alu_a_src_q;
    logic        alu_b_src_d,   alu_b_src_q;
    logic [3:0]  alu_op_d,      alu_op_q;
    logic [4:0]  br_op_d,       br_op_q;
    logic [2:0]  dm_ctrl_d,     dm_ctrl_q;
    logic [1:0]  wr_src_d,      wr_src_q;
    logic        valid_d,       valid_q;
    logic [15:0] stall_cnt_d,   stall_cnt_q;
    logic [15:0] flush_cnt_d,   flush_cnt_q;

    // Classify this cycle: any request makes a bubble; flush wins the count.
    always_comb begin
        bubble_s    = HDUStall | NextPCSrc;
        flush_evt_s = NextPCSrc;
        stall_evt_s = HDUStall & ~NextPCSrc;
    end

    // Next EX slot contents: DE fields on a normal load, all zeros on a bubble.
    always_comb begin
        pc_d        = 32'h0000_0000;
        ru_rs1_d    = 32'h0000_0000;
        ru_rs2_d    = 32'h0000_0000;
        imm_d       = 32'h0000_0000;
        rs1_d       = 5'd0;
        rs2_d       = 5'd0;
        rd_d        = 5'd0;
        ruwr_d      = 1'b0;
        dmwr_d      = 1'b0;
        dmrd_d      = 1'b0;
        alu_a_src_d = 1'b0;
        alu_b_src_d = 1'b0;
        alu_op_d    = 4'd0;
        br_op_d     = 5'd0;
        dm_ctrl_d   = 3'd0;
        wr_src_d    = 2'd0;
        valid_d     = 1'b0;
        if (bubble_s) begin
            // rd=0 / RUWr=0 / DMWr=0 / DMRd=0 / BrOp=0 keep the bubble inert
            // for forwarding, writeback, memory and hazard detection.
            valid_d = 1'b0;
        end else begin
            pc_d        = pc_de;
            ru_rs1_d    = ru_rs1_de;
            ru_rs2_d    = ru_rs2_de;
            imm_d       = imm_de;
            rs1_d       = rs1_de;
            rs2_d       = rs2_de;
            rd_d        = rd_de;
            ruwr_d      = RUWr_de;
            dmwr_d      = DMWr_de;
            dmrd_d      = DMRd_de;
            alu_a_src_d = ALUASrc_de;
            alu_b_src_d = ALUBSrc_de;
            alu_op_d    = ALUOp_de;
            br_op_d     = BrOp_de;
            dm_ctrl_d   = DMCtrl_de;
            wr_src_d    = RUDataWrSrc_de;
            valid_d     = 1'b1;
        end
    end

    // Next values of the saturating bubble counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt_s) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_evt_s) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Stage register with synchronous reset dominating every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= 32'h0000_0000;
            ru_rs1_q    <= 32'h0000_0000;
            ru_rs2_q    <= 32'h0000_0000;
            imm_q       <= 32'h0000_0000;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            rd_q        <= 5'd0;
            ruwr_q      <= 1'b0;
            dmwr_q      <= 1'b0;
            dmrd_q      <= 1'b0;
            alu_a_src_q <= 1'b0;
            alu_b_src_q <= 1'b0;
            alu_op_q    <= 4'd0;
            br_op_q     <= 5'd0;
            dm_ctrl_q   <= 3'd0;
            wr_src_q    <= 2'd0;
            valid_q     <= 1'b0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            pc_q        <= pc_d;
            ru_rs1_q    <= ru_rs1_d;
            ru_rs2_q    <= ru_rs2_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            ruwr_q      <= ruwr_d;
            dmwr_q      <= dmwr_d;
            dmrd_q      <= dmrd_d;
            alu_a_src_q <= alu_a_src_d;
            alu_b_src_q <= alu_b_src_d;
            alu_op_q    <= alu_op_d;
            br_op_q     <= br_op_d;
            dm_ctrl_q   <= dm_ctrl_d;
            wr_src_q    <= wr_src_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_ex          = pc_q;
    assign ru_rs1_ex      = ru_rs1_q;
    assign ru_rs2_ex      = ru_rs2_q;
    assign imm_ex         = imm_q;
    assign rs1_ex         = rs1_q;
    assign rs2_ex         = rs2_q;
    assign rd_ex          = rd_q;
    assign RUWr_ex        = ruwr_q;
    assign DMWr_ex        = dmwr_q;
    assign DMRd_ex        = dmrd_q;
    assign ALUASrc_ex     = alu_a_src_q;
    assign ALUBSrc_ex     = alu_b_src_q;
    assign ALUOp_ex       = alu_op_q;
    assign BrOp_ex        = br_op_q;
    assign DMCtrl_ex      = dm_ctrl_q;
    assign RUDataWrSrc_ex = wr_src_q;
    assign valid_ex       = valid_q;
    assign stall_cnt      = stall_cnt_q;
    assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_de_ex_pipeline_register.sv
// -----------------------------------------------------------------------------
// tb_de_ex_pipeline_register
//
// Directed self-checking bench for de_ex_pipeline_register. Inputs change
// 1 time unit after a rising edge; outputs are sampled at that same point,
// away from the active edge.
// -----------------------------------------------------------------------------
module tb_de_ex_pipeline_register;

    localparam int BW = 163;

    logic        clk = 1'b0;
    logic        rst;
    logic        HDUStall;
    logic        NextPCSrc;
    logic [31:0] pc_de, ru_rs1_de, ru_rs2_de, imm_de;
    logic [4:0]  rs1_de, rs2_de, rd_de;
    logic        RUWr_de, DMWr_de, DMRd_de, ALUASrc_de, ALUBSrc_de;
    logic [3:0]  ALUOp_de;
    logic [4:0]  BrOp_de;
    logic [2:0]  DMCtrl_de;
    logic [1:0]  RUDataWrSrc_de;

    logic [31:0] pc_ex, ru_rs1_ex, ru_rs2_ex, imm_ex;
    logic [4:0]  rs1_ex, rs2_ex, rd_ex;
    logic        RUWr_ex, DMWr_ex, DMRd_ex, ALUASrc_ex, ALUBSrc_ex;
    logic [3:0]  ALUOp_ex;
    logic [4:0]  BrOp_ex;
    logic [2:0]  DMCtrl_ex;
    logic [1:0]  RUDataWrSrc_ex;
    logic        valid_ex;
    logic [15:0] stall_cnt, flush_cnt;

    logic [BW-1:0] ex_bus;
    logic [BW-1:0] exp_bus;
    logic [BW-1:0] zero_bus;
    logic [15:0]   exp_stall;
    logic [15:0]   exp_flush;
    int            checks = 0;
    int            errors = 0;

    de_ex_pipeline_register dut (
        .clk(clk), .rst(rst), .HDUStall(HDUStall), .NextPCSrc(NextPCSrc),
        .pc_de(pc_de), .ru_rs1_de(ru_rs1_de), .ru_rs2_de(ru_rs2_de), .imm_de(imm_de),
        .rs1_de(rs1_de), .rs2_de(rs2_de), .rd_de(rd_de),
        .RUWr_de(RUWr_de), .DMWr_de(DMWr_de), .DMRd_de(DMRd_de),
        .ALUASrc_de(ALUASrc_de), .ALUBSrc_de(ALUBSrc_de),
        .ALUOp_de(ALUOp_de), .BrOp_de(BrOp_de), .DMCtrl_de(DMCtrl_de),
        .RUDataWrSrc_de(RUDataWrSrc_de),
        .pc_ex(pc_ex), .ru_rs1_ex(ru_rs1_ex), .ru_rs2_ex(ru_rs2_ex), .imm_ex(imm_ex),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
        .RUWr_ex(RUWr_ex), .DMWr_ex(DMWr_ex), .DMRd_ex(DMRd_ex),
        .ALUASrc_ex(ALUASrc_ex), .ALUBSrc_ex(ALUBSrc_ex),
        .ALUOp_ex(ALUOp_ex), .BrOp_ex(BrOp_ex), .DMCtrl_ex(DMCtrl_ex),
        .RUDataWrSrc_ex(RUDataWrSrc_ex),
        .valid_ex(valid_ex), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    assign ex_bus = {pc_ex, ru_rs1_ex, ru_rs2_ex, imm_ex, rs1_ex, rs2_ex, rd_ex,
                     RUWr_ex, DMWr_ex, DMRd_ex, ALUASrc_ex, ALUBSrc_ex,
                     ALUOp_ex, BrOp_ex, DMCtrl_ex, RUDataWrSrc_ex, valid_ex};

    // Expected EX image of the DE inputs currently driven (normal load).
    function automatic logic [BW-1:0] de_bus();
        return {pc_de, ru_rs1_de, ru_rs2_de, imm_de, rs1_de, rs2_de, rd_de,
                RUWr_de, DMWr_de, DMRd_de, ALUASrc_de, ALUBSrc_de,
                ALUOp_de, BrOp_de, DMCtrl_de, RUDataWrSrc_de, 1'b1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] imm,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [4:0] bits,
                         input logic [3:0] aluop, input logic [4:0] brop,
                         input logic [2:0] dmctrl, input logic [1:0] wrsrc);
        pc_de = pc; ru_rs1_de = r1; ru_rs2_de = r2; imm_de = imm;
        rs1_de = rs1; rs2_de = rs2; rd_de = rd;
        {RUWr_de, DMWr_de, DMRd_de, ALUASrc_de, ALUBSrc_de} = bits;
        ALUOp_de = aluop; BrOp_de = brop; DMCtrl_de = dmctrl; RUDataWrSrc_de = wrsrc;
    endtask

    task automatic test_reset();
        rst = 1'b1; HDUStall = 1'b0; NextPCSrc = 1'b0;
        drive(32'h40, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd3, 5'b10000,
              4'h1, 5'h2, 3'h1, 2'h1);
        tick();
        checks++;
        if (ex_bus !== zero_bus) begin
            errors++; $display("FAIL reset_outputs: got %h expected %h", ex_bus, zero_bus);
        end
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_counters: got %h/%h expected 0/0", stall_cnt, flush_cnt);
        end
        // Reset must win even with both bubble requests asserted.
        HDUStall = 1'b1; NextPCSrc = 1'b1;
        tick();
        checks++;
        if (ex_bus !== zero_bus || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_dominates: got %h %h/%h expected zeros", ex_bus, stall_cnt, flush_cnt);
        end
        HDUStall = 1'b0; NextPCSrc = 1'b0;
        exp_stall = 16'd0; exp_flush = 16'd0;
    endtask

    task automatic test_pass_through();
        rst = 1'b0;
        drive(32'h100, 32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFF0, 5'd6, 5'd8,
              5'd5, 5'b10000, 4'h3, 5'h00, 3'h2, 2'h0);
        exp_bus = de_bus();
        tick();
        checks++;
        if (pc_ex !== 32'h100 || rd_ex !== 5'd5 || RUWr_ex !== 1'b1 ||
            ALUOp_ex !== 4'h3 || imm_ex !== 32'hFFFF_FFF0 || valid_ex !== 1'b1) begin
            errors++; $display("FAIL pass_fields: got pc=%h rd=%0d ruwr=%b aluop=%h imm=%h v=%b expected 100/5/1/3/fffffff0/1",
                               pc_ex, rd_ex, RUWr_ex, ALUOp_ex, imm_ex, valid_ex);
        end
        checks++;
        if (ex_bus !== exp_bus) begin
            errors++; $display("FAIL pass_bus1: got %h expected %h", ex_bus, exp_bus);
        end
        // Complementary pattern; outputs must not move until the next edge.
        drive(32'hFFFF_FFFC, 32'h0F0F_0F0F, 32'hA5A5_A5A5, 32'h0000_0007, 5'd31, 5'd17,
              5'd30, 5'b01111, 4'hC, 5'h1F, 3'h5, 2'h2);
        #1;
        checks++;
        if (ex_bus !== exp_bus) begin
            errors++; $display("FAIL no_comb_path: got %h expected %h", ex_bus, exp_bus);
        end
        exp_bus = de_bus();
        tick();
        checks++;
        if (ex_bus !== exp_bus) begin
            errors++; $display("FAIL pass_bus2: got %h expected %h", ex_bus, exp_bus);
        end
    endtask

    task automatic test_load_use();
        // Load x9 enters EX.
        drive(32'h200, 32'h1000, 32'h0, 32'h8, 5'd2, 5'd0, 5'd9, 5'b10101,
              4'h0, 5'h0, 3'h2, 2'h1);
        tick();
        checks++;
        if (DMRd_ex !== 1'b1 || rd_ex !== 5'd9 || valid_ex !== 1'b1) begin
            errors++; $display("FAIL load_in_ex: got dmrd=%b rd=%0d v=%b expected 1/9/1", DMRd_ex, rd_ex, valid_ex);
        end
        // Dependent instruction stalls one cycle in DE.
        drive(32'h204, 32'h55, 32'h66, 32'h0, 5'd9, 5'd3, 5'd10, 5'b10000,
              4'h0, 5'h0, 3'h0, 2'h0);
        HDUStall = 1'b1;
        exp_stall = exp_stall + 16'd1;
        tick();
        checks++;
        if (rd_ex !== 5'd0 || RUWr_ex !== 1'b0 || DMRd_ex !== 1'b0 || valid_ex !== 1'b0 ||
            ex_bus !== zero_bus) begin
            errors++; $display("FAIL load_use_bubble: got %h expected %h", ex_bus, zero_bus);
        end
        checks++;
        if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
            errors++; $display("FAIL load_use_cnt: got %0d/%0d expected %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
        end
        HDUStall = 1'b0;
        exp_bus = de_bus();
        tick();
        checks++;
        if (ex_bus !== exp_bus) begin
            errors++; $display("FAIL load_use_resume: got %h expected %h", ex_bus, exp_bus);
        end
    endtask

    task automatic test_branch_flush();
        drive(32'h300, 32'h77, 32'h88, 32'h10, 5'd4, 5'd5, 5'd7, 5'b01000,
              4'h2, 5'h3, 3'h2, 2'h0);
        NextPCSrc = 1'b1;
        exp_flush = exp_flush + 16'd1;
        tick();
        checks++;
        if (DMWr_ex !== 1'b0 || rd_ex !== 5'd0 || valid_ex !== 1'b0 || ex_bus !== zero_bus) begin
            errors++; $display("FAIL flush_bubble: got %h expected %h", ex_bus, zero_bus);
        end
        checks++;
        if (flush_cnt !== exp_flush || stall_cnt !== exp_stall) begin
            errors++; $display("FAIL flush_cnt: got %0d/%0d expected %0d/%0d", flush_cnt, stall_cnt, exp_flush, exp_stall);
        end
        NextPCSrc = 1'b0;
    endtask

    task automatic test_simultaneous();
        drive(32'h400, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd12, 5'b11111,
              4'hF, 5'h1F, 3'h7, 2'h3);
        HDUStall = 1'b1; NextPCSrc = 1'b1;
        exp_flush = exp_flush + 16'd1;
        tick();
        checks++;
        if (ex_bus !== zero_bus) begin
            errors++; $display("FAIL simul_bubble: got %h expected %h", ex_bus, zero_bus);
        end
        checks++;
        if (flush_cnt !== exp_flush || stall_cnt !== exp_stall) begin
            errors++; $display("FAIL simul_cnt: got flush=%0d stall=%0d expected %0d/%0d", flush_cnt, stall_cnt, exp_flush, exp_stall);
        end
        HDUStall = 1'b0; NextPCSrc = 1'b0;
    endtask

    task automatic test_back_to_back();
        HDUStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            // Data changes every stalled cycle and must never leak through.
            drive(32'h500 + 32'(i), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  5'd31, 5'd31, 5'd31, 5'b11111, 4'hF, 5'h1F, 3'h7, 2'h3);
            exp_stall = exp_stall + 16'd1;
            tick();
            checks++;
            if (ex_bus !== zero_bus || stall_cnt !== exp_stall) begin
                errors++; $display("FAIL b2b_bubble%0d: got %h cnt=%0d expected zeros cnt=%0d", i, ex_bus, stall_cnt, exp_stall);
            end
        end
        HDUStall = 1'b0;
        drive(32'h50C, 32'h9, 32'hA, 32'hB, 5'd11, 5'd12, 5'd13, 5'b10010,
              4'h5, 5'h4, 3'h3, 2'h2);
        exp_bus = de_bus();
        tick();
        checks++;
        if (ex_bus !== exp_bus) begin
            errors++; $display("FAIL b2b_resume: got %h expected %h", ex_bus, exp_bus);
        end
    endtask

    task automatic test_mid_reset();
        drive(32'h600, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 5'b10000,
              4'h1, 5'h0, 3'h0, 2'h0);
        rst = 1'b1; HDUStall = 1'b1;
        tick();
        checks++;
        if (ex_bus !== zero_bus || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++; $display("FAIL mid_reset: got %h %0d/%0d expected zeros", ex_bus, stall_cnt, flush_cnt);
        end
        rst = 1'b0; HDUStall = 1'b0;
        exp_stall = 16'd0; exp_flush = 16'd0;
        exp_bus = de_bus();
        tick();
        checks++;
        if (ex_bus !== exp_bus) begin
            errors++; $display("FAIL first_after_reset: got %h expected %h", ex_bus, exp_bus);
        end
    endtask

    task automatic test_saturation();
        HDUStall = 1'b1; NextPCSrc = 1'b0;
        for (int i = 1; i <= 65540; i++) begin
            tick();
            if (i == 65534) begin
                checks++;
                if (stall_cnt !== 16'hFFFE) begin
                    errors++; $display("FAIL sat_near: got %h expected fffe", stall_cnt);
                end
            end
        end
        checks++;
        if (stall_cnt !== 16'hFFFF || flush_cnt !== 16'd0) begin
            errors++; $display("FAIL sat_stall: got %h/%h expected ffff/0000", stall_cnt, flush_cnt);
        end
        tick();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold: got %h expected ffff", stall_cnt);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++; $display("FAIL sat_reset: got %h expected 0000", stall_cnt);
        end
        rst = 1'b0; HDUStall = 1'b0;
    endtask

    initial begin
        zero_bus = {BW{1'b0}};
        rst = 1'b1; HDUStall = 1'b0; NextPCSrc = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'b00000,
              4'h0, 5'h0, 3'h0, 2'h0);
        #2;
        test_reset();
        test_pass_through();
        test_load_use();
        test_branch_flush();
        test_simultaneous();
        test_back_to_back();
        test_mid_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/de_ex_pipeline_register.md
DE_EX_PIPELINE_REGISTER -- requirements
Module: de_ex_pipeline_register

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge only.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 HDUStall  in  1  load-use stall request from hazard detection unit (DE stage).
REQ-004 NextPCSrc  in  1  taken branch/jump resolved in EX; flush request.
REQ-005 pc_de, ru_rs1_de, ru_rs2_de, imm_de  in  32 each  DE-stage PC, register-file read data, immediate.
REQ-006 rs1_de, rs2_de, rd_de  in  5 each  DE-stage register indices.
REQ-007 RUWr_de, DMWr_de, DMRd_de, ALUASrc_de, ALUBSrc_de  in  1 each  DE-stage control bits.
REQ-008 ALUOp_de 4, BrOp_de 5, DMCtrl_de 3, RUDataWrSrc_de 2  in  DE-stage control fields.
REQ-009 *_ex  out  same widths as REQ-005..REQ-008  registered copies of every DE field.
REQ-010 valid_ex  out  1  EX slot holds a real instruction (0 = bubble).
REQ-011 stall_cnt, flush_cnt  out  16 each  saturating event counters.

Function
REQ-012 Block SHALL be one register stage: every *_ex and valid_ex updates only on rising clk; no combinational path from any input to any output.
REQ-013 Normal load: HDUStall=0 and NextPCSrc=0 -> all *_ex <= *_de, valid_ex <= 1, one-cycle latency.
REQ-014 Bubble: HDUStall=1 or NextPCSrc=1 -> next-cycle RUWr_ex, DMWr_ex, DMRd_ex, valid_ex = 0; rd_ex, rs1_ex, rs2_ex = 0; BrOp_ex = 0 (no branch); all other *_ex = 0.
REQ-015 Bubble with rd_ex=0 and RUWr_ex=0 SHALL never trigger forwarding, register write, memory access or a further HDUStall.
REQ-016 HDUStall and NextPCSrc both 1 in the same cycle -> single bubble (REQ-014); flush_cnt increments, stall_cnt does not (flush has priority).
REQ-017 Block SHALL NOT hold: the DE instruction is held upstream by the IF/DE register and PC on HDUStall; this stage inserts exactly one bubble per stalled cycle.
REQ-018 Back-to-back HDUStall for N cycles -> N consecutive bubbles; first valid instruction loads the cycle after HDUStall drops.
REQ-019 stall_cnt +1 per rising edge with HDUStall=1 and NextPCSrc=0; flush_cnt +1 per rising edge with NextPCSrc=1.
REQ-020 Both counters SHALL saturate at 16'hFFFF, no wrap-around.
REQ-021 Input data values (pc_de, ru_rs*_de, imm_de) SHALL have no effect on any output during a bubble cycle.

Reset
REQ-022 rst=1 at a rising edge -> all *_ex = 0, valid_ex = 0, stall_cnt = 0, flush_cnt = 0, regardless of HDUStall/NextPCSrc.
REQ-023 rst SHALL dominate all other inputs; reset asserted mid-stream discards the in-flight EX instruction.
REQ-024 First rising edge with rst=0 SHALL perform a normal load or bubble per REQ-013/REQ-014.
REQ-025 Output values before the first reset edge are undefined; bench SHALL not check them.

Verification
REQ-026 Reset: rst=1 one cycle with pc_de=32'h40, RUWr_de=1 -> all outputs 0, valid_ex=0, counters 0.
REQ-027 Pass-through: pc_de=32'h100, rd_de=5, RUWr_de=1, ALUOp_de=4'h3, imm_de=32'hFFFF_FFF0 -> next cycle same values on *_ex, valid_ex=1.
REQ-028 Load-use: DMRd_ex=1 load in EX, HDUStall=1 one cycle -> bubble (rd_ex=0, RUWr_ex=0, DMRd_ex=0, valid_ex=0), stall_cnt=1; following cycle held DE instruction loads with valid_ex=1.
REQ-029 Branch flush: NextPCSrc=1 with DMWr_de=1, rd_de=7 -> DMWr_ex=0, rd_ex=0, valid_ex=0, flush_cnt=1.
REQ-030 Simultaneous: HDUStall=1 and NextPCSrc=1 -> one bubble, flush_cnt +1, stall_cnt unchanged.
REQ-031 Saturation: HDUStall=1 for 65 540 cycles -> stall_cnt = 16'hFFFF and stays there; then rst=1 -> 0.
